// File: rtl/nonce_dispatcher_if.sv
// Dispatch, result and found-nonce channels
// between the nonce dispatcher and the hash pipeline.
interface nonce_dispatcher_if;
   logic        disp_valid;
   logic [31:0] disp_nonce;
   logic        disp_ready;
   logic        res_valid;
   logic        res_pass;
   logic        found_valid;
   logic [31:0] found_nonce;
   logic        found_ready;

   modport master (
      output disp_valid,
      output disp_nonce,
      input  disp_ready,
      input  res_valid,
      input  res_pass,
      output found_valid,
      output found_nonce,
      input  found_ready
   );

   modport slave (
      input  disp_valid,
      input  disp_nonce,
      output disp_ready,
      output res_valid,
      output res_pass,
      input  found_valid,
      input  found_nonce,
      output found_ready
   );
endinterface

// File: rtl/nonce_dispatcher.sv
// Issues a nonce range to a hash pipeline, retires
// in-order results and queues passing nonces.
module nonce_dispatcher #(
   parameter int MAX_INFLIGHT = 64,
   parameter int FOUND_DEPTH  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [31:0]        nonce_base,
   input  logic [31:0]        nonce_count,
   input  logic               abort,
   nonce_dispatcher_if.master bus,
   output logic               busy,
   output logic               done,
   output logic               overflow
);
   localparam int IW = $clog2(MAX_INFLIGHT) + 1;
   localparam int AW = $clog2(FOUND_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [31:0]   base;
   logic [32:0]   count;
   logic [32:0]   issued;
   logic [31:0]   retired;
   logic [IW-1:0] inflight;
   logic [IW-1:0] inflight_nx;
   logic [31:0]   fifo [FOUND_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          disp_fire;
   logic          res_fire;
   logic          push;
   logic          pop;
   logic          wr_en;
   logic          full;
   logic          empty;
   logic          last;

   assign empty = wr_ptr == rd_ptr;
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // abort withdraws the offer in the same cycle
   assign bus.disp_valid = (state == RUN) && !abort &&
                           (issued < count) &&
                           (inflight < IW'(MAX_INFLIGHT));
   assign bus.disp_nonce = bus.disp_valid ?
                           base + issued[31:0] : '0;

   assign disp_fire = bus.disp_valid && bus.disp_ready;
   assign res_fire  = bus.res_valid && (inflight != '0);
   assign push      = res_fire && bus.res_pass;
   assign pop       = !empty && bus.found_ready;
   assign wr_en     = push && (!full || pop);
   assign last      = disp_fire && (issued + 33'd1 == count);

   assign inflight_nx = inflight + IW'(disp_fire)
                                 - IW'(res_fire);

   assign bus.found_valid = !empty;
   assign bus.found_nonce = empty ? '0 :
                            fifo[rd_ptr[AW-1:0]];
   assign busy = state != IDLE;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last || abort) state_nx = DRAIN;
         DRAIN:   if (inflight_nx == '0) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         base     <= '0;
         count    <= '0;
         issued   <= '0;
         retired  <= '0;
         inflight <= '0;
         done     <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= (state == DRAIN) && (state_nx == IDLE);
         if (state == IDLE) begin
            if (start) begin
               base     <= nonce_base;
               count    <= (nonce_count == '0) ?
                           33'h1_0000_0000 :
                           {1'b0, nonce_count};
               issued   <= '0;
               retired  <= '0;
               inflight <= '0;
            end
         end else begin
            if (disp_fire) issued <= issued + 33'd1;
            if (res_fire) retired <= retired + 32'd1;
            inflight <= inflight_nx;
         end
      end
   end

   // results retire in dispatch order, so base+retired names them
   always_ff @(posedge clk) begin
      if (wr_en) fifo[wr_ptr[AW-1:0]] <= base + retired;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (state == IDLE && start)
            overflow <= 1'b0;
         else if (push && full && !pop)
            overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_nonce_dispatcher.sv
// Randomized and directed bench for nonce_dispatcher
// against a queue-based reference model.
module tb_nonce_dispatcher;
   localparam int MI = 4;
   localparam int FD = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] nonce_base = '0;
   logic [31:0] nonce_count = '0;
   logic        busy;
   logic        done;
   logic        overflow;

   nonce_dispatcher_if bus();

   nonce_dispatcher #(
      .MAX_INFLIGHT(MI),
      .FOUND_DEPTH(FD)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .nonce_base(nonce_base),
      .nonce_count(nonce_count),
      .abort(abort),
      .bus(bus),
      .busy(busy),
      .done(done),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total = 0;

   task automatic chk(string nm, logic [31:0] act,
                      logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %h want %h", nm, act, exp);
      else
         passed++;
   endtask

   // reference model: 0 idle, 1 run, 2 drain
   int          mode = 0;
   logic [31:0] m_base = '0;
   longint      m_cnt = 0;
   longint      m_iss = 0;
   bit          m_ovf = 0;
   bit          m_done = 0;
   logic [31:0] q_fly[$];
   logic [31:0] q_found[$];
   logic [31:0] seen[$];

   always @(negedge clk) begin
      bit          ev;
      bit          df;
      bit          rf;
      bit          pp;
      logic [31:0] en;
      logic [31:0] fn;
      if (!rst_n) begin
         mode = 0;
         m_base = '0;
         m_cnt = 0;
         m_iss = 0;
         m_ovf = 0;
         m_done = 0;
         q_fly.delete();
         q_found.delete();
      end
      ev = (mode == 1) && !abort && (m_iss < m_cnt) &&
           (q_fly.size() < MI);
      en = ev ? m_base + 32'(m_iss) : 32'd0;
      fn = (q_found.size() > 0) ? q_found[0] : 32'd0;
      chk("disp_valid", bus.disp_valid, ev);
      chk("disp_nonce", bus.disp_nonce, en);
      chk("found_valid", bus.found_valid,
          q_found.size() > 0);
      chk("found_nonce", bus.found_nonce, fn);
      chk("busy", busy, mode != 0);
      chk("done", done, m_done);
      chk("overflow", overflow, m_ovf);
      if (bus.disp_valid && bus.disp_ready)
         seen.push_back(bus.disp_nonce);
      if (rst_n) begin
         df = ev && bus.disp_ready;
         rf = bus.res_valid && (q_fly.size() > 0);
         pp = (q_found.size() > 0) && bus.found_ready;
         m_done = 0;
         if (pp) void'(q_found.pop_front());
         if (rf) begin
            en = q_fly.pop_front();
            if (bus.res_pass) begin
               if (q_found.size() < FD)
                  q_found.push_back(en);
               else
                  m_ovf = 1;
            end
         end
         if (df) begin
            q_fly.push_back(m_base + 32'(m_iss));
            m_iss++;
         end
         case (mode)
            0: if (start) begin
               mode = 1;
               m_base = nonce_base;
               m_cnt = (nonce_count == 0) ? 64'h1_0000_0000
                       : longint'(nonce_count);
               m_iss = 0;
               m_ovf = 0;
               q_fly.delete();
            end
            1: if ((df && m_iss == m_cnt) || abort) mode = 2;
            2: if (q_fly.size() == 0) begin
               mode = 0;
               m_done = 1;
            end
            default: mode = 0;
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(logic [31:0] b, logic [31:0] c);
      nonce_base = b;
      nonce_count = c;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(string nm, bit pass);
      int n;
      n = 0;
      bus.res_valid = 1'b1;
      bus.res_pass = pass;
      while (busy && n < 300) begin
         step();
         n++;
      end
      bus.res_valid = 1'b0;
      bus.res_pass = 1'b0;
      chk(nm, {busy, done}, 2'b01);
   endtask

   task automatic chk_seen(string nm, int i,
                           logic [31:0] exp);
      chk(nm, (i < seen.size()) ? seen[i] : 32'hDEAD_BEEF,
          exp);
   endtask

   initial begin
      int n;
      logic [31:0] wrap_exp [3];
      wrap_exp[0] = 32'hFFFF_FFFE;
      wrap_exp[1] = 32'hFFFF_FFFF;
      wrap_exp[2] = 32'h0000_0000;
      bus.disp_ready = 1'b0;
      bus.res_valid = 1'b0;
      bus.res_pass = 1'b0;
      bus.found_ready = 1'b0;
      step();
      chk("rst_state", {bus.disp_valid, bus.found_valid,
          busy, done, overflow}, 0);
      step();
      rst_n = 1'b1;
      step();

      bus.disp_ready = 1'b1;
      seen.delete();
      launch(32'h100, 32'd4);
      step();
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         bus.res_valid = 1'b1;
         bus.res_pass = (i == 1);
         step();
      end
      bus.res_valid = 1'b0;
      bus.res_pass = 1'b0;
      chk("basic_done", {busy, done}, 2'b01);
      chk("basic_found", bus.found_nonce, 32'h101);
      chk("basic_count", seen.size(), 4);
      for (int i = 0; i < 4; i++)
         chk_seen("basic_seq", i, 32'h100 + i);
      bus.found_ready = 1'b1;
      step();
      bus.found_ready = 1'b0;
      chk("basic_pop", bus.found_valid, 0);

      seen.delete();
      launch(32'hFFFF_FFFE, 32'd3);
      step();
      step();
      step();
      wait_done("wrap_done", 1'b0);
      chk("wrap_count", seen.size(), 3);
      for (int i = 0; i < 3; i++)
         chk_seen("wrap_seq", i, wrap_exp[i]);

      seen.delete();
      launch(32'h0, 32'd10);
      repeat (20) step();
      chk("cap_count", seen.size(), MI);
      chk("cap_stall", bus.disp_valid, 0);
      bus.res_valid = 1'b1;
      step();
      bus.res_valid = 1'b0;
      chk("cap_resume", bus.disp_valid, 1);
      wait_done("cap_done", 1'b0);
      chk("cap_total", seen.size(), 10);

      launch(32'h200, 32'd6);
      wait_done("ovf_done", 1'b1);
      chk("ovf_set", overflow, 1);
      chk("ovf_head", bus.found_nonce, 32'h200);
      launch(32'h300, 32'd1);
      chk("ovf_clear", overflow, 0);
      chk("ovf_keep", bus.found_valid, 1);
      wait_done("ovf_done2", 1'b0);
      for (int i = 0; i < FD; i++) begin
         chk("ovf_fifo", bus.found_nonce, 32'h200 + i);
         bus.found_ready = 1'b1;
         step();
         bus.found_ready = 1'b0;
      end
      chk("ovf_empty", bus.found_valid, 0);

      seen.delete();
      launch(32'h1000, 32'd100);
      n = 0;
      while (seen.size() < 5 && n < 50) begin
         bus.res_valid = 1'b1;
         step();
         n++;
      end
      abort = 1'b1;
      bus.res_valid = 1'b0;
      step();
      abort = 1'b0;
      chk("abort_stop", seen.size(), 5);
      chk("abort_drain", busy, 1);
      wait_done("abort_done", 1'b0);
      chk("abort_total", seen.size(), 5);

      seen.delete();
      launch(32'h500, 32'd50);
      n = 0;
      while (seen.size() < 3 && n < 50) begin
         step();
         n++;
      end
      bus.res_valid = 1'b1;
      bus.res_pass = 1'b1;
      step();
      bus.res_valid = 1'b0;
      bus.res_pass = 1'b0;
      bus.disp_ready = 1'b0;
      chk("mid_found", bus.found_nonce, 32'h500);
      chk("mid_busy", bus.disp_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst", {bus.disp_valid, bus.found_valid,
          busy, done, overflow}, 0);
      chk("mid_rst_dn", bus.disp_nonce, 0);
      chk("mid_rst_fn", bus.found_nonce, 0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.res_valid = 1'b1;
         bus.res_pass = 1'b1;
         step();
      end
      bus.res_valid = 1'b0;
      bus.res_pass = 1'b0;
      chk("late_res", {bus.found_valid, busy}, 0);

      for (int c = 0; c < 4000; c++) begin
         start = ($urandom_range(0, 5) == 0);
         nonce_base = ($urandom_range(0, 3) == 0) ?
                      32'hFFFF_FFF8 + $urandom_range(0, 7) :
                      $urandom;
         nonce_count = $urandom_range(0, 12);
         abort = ($urandom_range(0, 39) == 0);
         bus.disp_ready = ($urandom_range(0, 3) != 0);
         bus.res_valid = ($urandom_range(0, 1) == 0);
         bus.res_pass = ($urandom_range(0, 3) == 0);
         bus.found_ready = ($urandom_range(0, 3) == 0);
         rst_n = ($urandom_range(0, 599) != 0);
         step();
      end
      rst_n = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      bus.res_valid = 1'b0;
      step();
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/nonce_dispatcher.md
NONCE_DISPATCHER -- requirements
Module: nonce_dispatcher

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 64: maximum nonces issued but not yet retired (power of two, 2..256).
REQ-002 SHALL have parameter FOUND_DEPTH, default 4: found-nonce FIFO entries (power of two, 2..16).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle job launch; sampled only in IDLE.
REQ-006 nonce_base  input  32  first nonce of job; captured on accepted start.
REQ-007 nonce_count  input  32  nonces in job; captured on accepted start; 0 means 2^32.
REQ-008 abort  input  1  stop issuing; drain in-flight work.
REQ-009 disp_valid  output  1  nonce offered to hash pipeline.
REQ-010 disp_nonce  output  32  offered nonce.
REQ-011 disp_ready  input  1  pipeline accepts; transfer when disp_valid && disp_ready.
REQ-012 res_valid  input  1  one result per dispatched nonce, in dispatch order, unstallable.
REQ-013 res_pass  input  1  validator verdict for that result (1 = leading words zero).
REQ-014 found_valid  output  1  found FIFO non-empty.
REQ-015 found_nonce  output  32  FIFO head nonce.
REQ-016 found_ready  input  1  pop when found_valid && found_ready.
REQ-017 busy  output  1  high in RUN and DRAIN.
REQ-018 done  output  1  one-cycle pulse on DRAIN->IDLE.
REQ-019 overflow  output  1  sticky: a passing nonce was dropped; cleared by accepted start.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-021 IDLE->RUN on start; captures base/count, zeroes issue, retire and in-flight counters, clears overflow.
REQ-022 RUN: disp_valid SHALL be 1 iff issued < count and inflight < MAX_INFLIGHT; disp_nonce = base + issued (mod 2^32, wraps 0xFFFFFFFF->0).
REQ-023 Each dispatch transfer SHALL increment issued and inflight; each res_valid SHALL decrement inflight and increment retired.
REQ-024 Simultaneous dispatch and res_valid in one cycle SHALL leave inflight unchanged.
REQ-025 res_valid with inflight == 0 SHALL be ignored (no counter change, no FIFO push).
REQ-026 Retiring nonce SHALL equal base + retired (mod 2^32); no per-nonce storage.
REQ-027 res_valid && res_pass SHALL push retiring nonce into found FIFO same edge; visible on found_nonce next cycle if FIFO was empty.
REQ-028 Push when FIFO full and no pop that cycle SHALL drop nonce and set overflow; push+pop on full SHALL succeed.
REQ-029 RUN->DRAIN when issued == count (last transfer) or abort asserted; disp_valid SHALL be 0 in DRAIN.
REQ-030 DRAIN->IDLE when inflight == 0 (including cycle of final res_valid bringing it to 0); done pulses that cycle.
REQ-031 abort in IDLE or DRAIN SHALL have no effect; start outside IDLE SHALL be ignored.
REQ-032 Found FIFO SHALL keep contents across jobs; only reset clears it.
REQ-033 disp_valid, once high, SHALL remain high with stable disp_nonce until transfer, except on abort.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, all counters 0, FIFO empty, disp_valid=0, disp_nonce=0, found_valid=0, found_nonce=0, busy=0, done=0, overflow=0.
REQ-035 Reset mid-job SHALL discard all in-flight accounting; results arriving after release in IDLE SHALL be ignored.

Verification
REQ-036 base=0x100, count=4, disp_ready=1, results 3 cycles later, pass on 2nd -> nonces 0x100..0x103 dispatched, found_nonce=0x101, done one cycle after 4th result.
REQ-037 base=0xFFFFFFFE, count=3 -> dispatch 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-038 MAX_INFLIGHT=4, count=10, no results for 20 cycles -> exactly 4 transfers, disp_valid=0 until first res_valid.
REQ-039 FOUND_DEPTH=4, found_ready=0, 6 passing results -> FIFO holds first 4 nonces, overflow=1; next start clears overflow, FIFO still 4.
REQ-040 abort after 5 of 100 dispatched -> no further dispatch, DRAIN until 5 results, done pulse, busy=0.
REQ-041 rst_n low mid-RUN with 3 in flight -> all outputs zero asynchronously; 3 late res_valid/res_pass after release produce no FIFO push.
